// File: rtl/hazard_pkg.sv
// +--------------------------------------------------------------------------+
// | hazard_pkg: shared types/constants for the P5 hazard scheduler. Rev 1.0  |
// +--------------------------------------------------------------------------+
`default_nettype none

package hazard_pkg;

  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;
  localparam logic [1:0] FWD_W   = 2'd3;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef enum logic [1:0] {
    MD_NONE = 2'd0,
    MD_MULT = 2'd1,
    MD_DIV  = 2'd2
  } md_kind_e;

  typedef struct packed {
    logic [4:0] wa;
    logic [1:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
    md_kind_e   md;
  } sb_entry_t;

  // Moving one stage down the pipe brings the result one cycle closer.
  function automatic sb_entry_t sb_age(input sb_entry_t e);
    sb_entry_t a;
    a = e;
    if (e.tnew != 2'd0) a.tnew = e.tnew - 2'd1;
    return a;
  endfunction

  function automatic logic sb_match(input sb_entry_t x, input logic [4:0] r);
    return (r != 5'd0) && (x.wa == r);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_fwd_sel.sv
// +--------------------------------------------------------------------------+
// | hazard_fwd_sel: priority match of one operand over three slots. Rev 1.0  |
// +--------------------------------------------------------------------------+
`default_nettype none

module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter logic [1:0] SEL0 = FWD_E,
  parameter logic [1:0] SEL1 = FWD_M,
  parameter logic [1:0] SEL2 = FWD_W
) (
  input  logic [4:0]      src,
  input  logic [2:0][4:0] wa,
  input  logic [2:0][1:0] tnew,
  output logic [1:0]      sel
);

  // Slot 0 is nearest; later assignments override so slot 0 wins.
  always_comb begin
    sel = FWD_GRF;
    if (src != 5'd0) begin
      if (wa[2] == src && tnew[2] == 2'd0) sel = SEL2;
      if (wa[1] == src && tnew[1] == 2'd0) sel = SEL1;
      if (wa[0] == src && tnew[0] == 2'd0) sel = SEL0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// +--------------------------------------------------------------------------+
// | hazard_ctrl: P5 stall/forward scheduler; HAZARD_FWD_EN enables bypass.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_rs_tuse,
  input  logic [1:0] D_rt_tuse,
  input  logic [4:0] D_wa,
  input  logic [1:0] D_tnew,
  input  logic [1:0] D_md_start,
  input  logic       D_md_use,
  output logic       stall,
  output logic       md_busy,
  output logic [1:0] fwd_D_rs,
  output logic [1:0] fwd_D_rt,
  output logic [1:0] fwd_E_rs,
  output logic [1:0] fwd_E_rt,
  output logic [1:0] fwd_M_rt
);

  localparam int CNT_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  sb_entry_t        sb_e, sb_m, sb_w;
  sb_entry_t        d_entry;
  logic [CNT_W-1:0] md_cnt;
  logic             data_hzd;
  logic             md_hzd;
  logic             unused_sb;

  // With bypassing, only a result not ready by tuse stalls; without, any hit does.
  function automatic logic src_hazard(input sb_entry_t x, input logic [4:0] r,
                                      input logic [1:0] tuse);
`ifdef HAZARD_FWD_EN
    return (tuse != TUSE_NONE) && sb_match(x, r) && (tuse < x.tnew);
`else
    return (tuse != TUSE_NONE) && sb_match(x, r);
`endif
  endfunction

  assign d_entry = '{wa: D_wa, tnew: D_tnew, rs: D_rs, rt: D_rt,
                     md: md_kind_e'(D_md_start)};

  assign data_hzd = src_hazard(sb_e, D_rs, D_rs_tuse) | src_hazard(sb_m, D_rs, D_rs_tuse) |
                    src_hazard(sb_e, D_rt, D_rt_tuse) | src_hazard(sb_m, D_rt, D_rt_tuse);
  assign md_busy  = (md_cnt != '0);
  assign md_hzd   = D_md_use && (md_busy || sb_e.md != MD_NONE);
  assign stall    = data_hzd | md_hzd;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sb_e   <= '0;
      sb_m   <= '0;
      sb_w   <= '0;
      md_cnt <= '0;
    end else begin
      sb_e <= stall ? '0 : d_entry;
      sb_m <= sb_age(sb_e);
      sb_w <= sb_age(sb_m);
      if (sb_e.md == MD_MULT)     md_cnt <= CNT_W'(MULT_CYC);
      else if (sb_e.md == MD_DIV) md_cnt <= CNT_W'(DIV_CYC);
      else if (md_cnt != '0)      md_cnt <= md_cnt - CNT_W'(1);
    end
  end

`ifdef HAZARD_FWD_EN
  hazard_fwd_sel #(.SEL0(FWD_E), .SEL1(FWD_M), .SEL2(FWD_W)) u_fwd_d_rs (
    .src(D_rs), .wa({sb_w.wa, sb_m.wa, sb_e.wa}),
    .tnew({sb_w.tnew, sb_m.tnew, sb_e.tnew}), .sel(fwd_D_rs));

  hazard_fwd_sel #(.SEL0(FWD_E), .SEL1(FWD_M), .SEL2(FWD_W)) u_fwd_d_rt (
    .src(D_rt), .wa({sb_w.wa, sb_m.wa, sb_e.wa}),
    .tnew({sb_w.tnew, sb_m.tnew, sb_e.tnew}), .sel(fwd_D_rt));

  hazard_fwd_sel #(.SEL0(FWD_M), .SEL1(FWD_W), .SEL2(FWD_GRF)) u_fwd_e_rs (
    .src(sb_e.rs), .wa({5'd0, sb_w.wa, sb_m.wa}),
    .tnew({2'd0, sb_w.tnew, sb_m.tnew}), .sel(fwd_E_rs));

  hazard_fwd_sel #(.SEL0(FWD_M), .SEL1(FWD_W), .SEL2(FWD_GRF)) u_fwd_e_rt (
    .src(sb_e.rt), .wa({5'd0, sb_w.wa, sb_m.wa}),
    .tnew({2'd0, sb_w.tnew, sb_m.tnew}), .sel(fwd_E_rt));

  hazard_fwd_sel #(.SEL0(FWD_W), .SEL1(FWD_GRF), .SEL2(FWD_GRF)) u_fwd_m_rt (
    .src(sb_m.rt), .wa({10'd0, sb_w.wa}),
    .tnew({4'd0, sb_w.tnew}), .sel(fwd_M_rt));
`else
  assign fwd_D_rs = FWD_GRF;
  assign fwd_D_rt = FWD_GRF;
  assign fwd_E_rs = FWD_GRF;
  assign fwd_E_rt = FWD_GRF;
  assign fwd_M_rt = FWD_GRF;
`endif

  assign unused_sb = ^sb_w;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_hazard_ctrl: scoreboard bench with pipeline reference model. Rev 1.0  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_hazard_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] rs_tuse;
    logic [1:0] rt_tuse;
    logic [4:0] wa;
    logic [1:0] tnew;
    logic [1:0] md_start;
    logic       md_use;
  } ins_t;

  typedef struct packed {
    logic       stall;
    logic       busy;
    logic [1:0] fdrs;
    logic [1:0] fdrt;
    logic [1:0] fers;
    logic [1:0] fert;
    logic [1:0] fmrt;
  } out_t;

  logic       clk;
  logic       reset;
  logic [4:0] D_rs, D_rt, D_wa;
  logic [1:0] D_rs_tuse, D_rt_tuse, D_tnew, D_md_start;
  logic       D_md_use;
  logic       stall, md_busy;
  logic [1:0] fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt;

  hazard_ctrl #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N)) dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse),
    .D_wa(D_wa), .D_tnew(D_tnew), .D_md_start(D_md_start), .D_md_use(D_md_use),
    .stall(stall), .md_busy(md_busy),
    .fwd_D_rs(fwd_D_rs), .fwd_D_rt(fwd_D_rt),
    .fwd_E_rs(fwd_E_rs), .fwd_E_rt(fwd_E_rt), .fwd_M_rt(fwd_M_rt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: instructions in flight, index 0 = E, 1 = M, 2 = W.
  ins_t pipe [3];
  int   edge_no;
  int   md_until;
  out_t expq [$];
  int   n_checks;
  int   n_fail;

  function automatic int rem_tnew(int i);
    return (int'(pipe[i].tnew) > i) ? int'(pipe[i].tnew) - i : 0;
  endfunction

  function automatic logic [1:0] fwd_of(logic [4:0] r, int lo, int hi);
    for (int i = lo; i <= hi; i++)
      if (FWD && r != 5'd0 && pipe[i].wa == r && rem_tnew(i) == 0) return 2'(i + 1);
    return 2'd0;
  endfunction

  function automatic logic blocks(logic [4:0] r, logic [1:0] tuse);
    if (tuse == 2'd3 || r == 5'd0) return 1'b0;
    for (int i = 0; i <= 1; i++)
      if (pipe[i].wa == r && (!FWD || int'(tuse) < rem_tnew(i))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic out_t expect_out(ins_t d);
    out_t e;
    logic busy;
    busy    = (edge_no < md_until);
    e.busy  = busy;
    e.stall = blocks(d.rs, d.rs_tuse) | blocks(d.rt, d.rt_tuse) |
              (d.md_use && (busy || pipe[0].md_start != 2'd0));
    e.fdrs  = fwd_of(d.rs, 0, 2);
    e.fdrt  = fwd_of(d.rt, 0, 2);
    e.fers  = fwd_of(pipe[0].rs, 1, 2);
    e.fert  = fwd_of(pipe[0].rt, 1, 2);
    e.fmrt  = fwd_of(pipe[1].rt, 2, 2);
    return e;
  endfunction

  function automatic ins_t mk(int rs, int rt, int rs_tuse, int rt_tuse,
                              int wa, int tnew, int md_start, int md_use);
    ins_t d;
    d.rs = 5'(rs); d.rt = 5'(rt); d.rs_tuse = 2'(rs_tuse); d.rt_tuse = 2'(rt_tuse);
    d.wa = 5'(wa); d.tnew = 2'(tnew); d.md_start = 2'(md_start); d.md_use = 1'(md_use);
    return d;
  endfunction

  function automatic ins_t rand_ins();
    logic [4:0] regs [5];
    int         r;
    ins_t       d;
    regs = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd31};
    d.rs      = regs[$urandom_range(0, 4)];
    d.rt      = regs[$urandom_range(0, 4)];
    d.wa      = regs[$urandom_range(0, 4)];
    d.rs_tuse = 2'($urandom_range(0, 3));
    d.rt_tuse = 2'($urandom_range(0, 3));
    d.tnew    = 2'($urandom_range(0, 2));
    r = int'($urandom_range(0, 15));
    d.md_start = (r == 0) ? 2'd1 : (r == 1) ? 2'd2 : 2'd0;
    d.md_use   = (d.md_start != 2'd0) || ($urandom_range(0, 5) == 0);
    return d;
  endfunction

  task automatic check(string name, logic [1:0] got, logic [1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_no, got, exp);
    end
  endtask

  task automatic step(input ins_t d, input logic rst_n, output logic stalled);
    out_t e;
    e = expect_out(d);
    reset = rst_n;
    D_rs = d.rs; D_rt = d.rt; D_rs_tuse = d.rs_tuse; D_rt_tuse = d.rt_tuse;
    D_wa = d.wa; D_tnew = d.tnew; D_md_start = d.md_start; D_md_use = d.md_use;
    expq.push_back(e);
    stalled = e.stall;
    @(posedge clk);
    edge_no++;
    if (!rst_n) begin
      pipe     = '{default: '0};
      md_until = edge_no;
    end else begin
      if (pipe[0].md_start == 2'd1)      md_until = edge_no + MULT_N;
      else if (pipe[0].md_start == 2'd2) md_until = edge_no + DIV_N;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = e.stall ? ins_t'(0) : d;
    end
    #1;
  endtask

  // Holds the instruction in D while the reference says it stalls.
  task automatic issue(input ins_t d);
    logic s;
    int   guard;
    guard = 0;
    do begin
      step(d, 1'b1, s);
      guard++;
    end while (s && guard < 40);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        out_t e;
        e = expq.pop_front();
        check("stall", {1'b0, stall}, {1'b0, e.stall});
        check("md_busy", {1'b0, md_busy}, {1'b0, e.busy});
        check("fwd_D_rs", fwd_D_rs, e.fdrs);
        check("fwd_D_rt", fwd_D_rt, e.fdrt);
        check("fwd_E_rs", fwd_E_rs, e.fers);
        check("fwd_E_rt", fwd_E_rt, e.fert);
        check("fwd_M_rt", fwd_M_rt, e.fmrt);
      end
    end
  end

  initial begin : stimulus
    ins_t nop, mflo, cur;
    logic s;
    n_checks = 0;
    n_fail   = 0;
    edge_no  = 0;
    md_until = 0;
    pipe     = '{default: '0};
    nop  = mk(0, 0, 3, 3, 0, 0, 0, 0);
    mflo = mk(0, 0, 3, 3, 7, 1, 0, 1);
    reset = 1'b0;
    D_rs = '0; D_rt = '0; D_rs_tuse = 2'd3; D_rt_tuse = 2'd3;
    D_wa = '0; D_tnew = '0; D_md_start = '0; D_md_use = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    step(nop, 1'b0, s);
    // lw $1 then addu $2,$1,$3
    issue(mk(29, 0, 1, 3, 1, 2, 0, 0));
    issue(mk(1, 3, 1, 1, 2, 1, 0, 0));
    repeat (3) issue(nop);
    // addu $1 then beq $1,$0
    issue(mk(4, 5, 1, 1, 1, 1, 0, 0));
    issue(mk(1, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) issue(nop);
    // jal then jr $31
    issue(mk(0, 0, 3, 3, 31, 0, 0, 0));
    issue(mk(31, 0, 0, 3, 0, 0, 0, 0));
    repeat (3) issue(nop);
    // writes to $0 never hazard
    issue(mk(4, 5, 1, 1, 0, 1, 0, 0));
    issue(mk(0, 0, 1, 1, 6, 1, 0, 0));
    repeat (3) issue(nop);
    // div, gap, mflo held until the unit drains
    issue(mk(8, 9, 1, 1, 0, 0, 2, 1));
    issue(nop);
    issue(mflo);
    repeat (3) issue(nop);
    // mult followed immediately by mfhi
    issue(mk(8, 9, 1, 1, 0, 0, 1, 1));
    issue(mflo);
    repeat (3) issue(nop);
    // reset on the 5th busy cycle of a div
    issue(mk(8, 9, 1, 1, 0, 0, 2, 1));
    step(mflo, 1'b1, s);
    repeat (4) step(mflo, 1'b1, s);
    step(mflo, 1'b0, s);
    step(mflo, 1'b1, s);
    repeat (3) issue(nop);
    // back-to-back dependent ALU ops
    issue(mk(4, 5, 1, 1, 1, 1, 0, 0));
    issue(mk(1, 1, 1, 1, 2, 1, 0, 0));
    repeat (3) issue(nop);

    cur = rand_ins();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        step(cur, 1'b0, s);
        cur = rand_ins();
      end else begin
        step(cur, 1'b1, s);
        if (!s) cur = rand_ins();
      end
    end
    repeat (3) step(nop, 1'b1, s);

    @(negedge clk);
    #1;
    n_checks++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/forward scheduler for the 5-stage P5 pipeline (F/D/E/M/W).
- Takes decoded register usage of the instruction in D and keeps its own scoreboard of (dest reg, Tnew, source regs) for E/M/W, advancing in lockstep with the pipeline registers.
- Produces the freeze/bubble controls and all forwarding mux selects.
- Also sequences the multi-cycle mult/div unit and stalls HI/LO users while it is busy.

Parameters:
- MULT_CYC, 5, busy cycles after a mult/multu enters E
- DIV_CYC, 10, busy cycles after a div/divu enters E

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-low; 0 at a rising edge clears all state
- D_rs  in  5  rs field of instruction in D
- D_rt  in  5  rt field of instruction in D
- D_rs_tuse  in  2  cycles (from D) until rs is needed; 3 = not read
- D_rt_tuse  in  2  same for rt
- D_wa  in  5  destination GRF address; 0 = no write
- D_tnew  in  2  cycles until result is ready, counted at E entry (jal=0, ALU=1, load=2)
- D_md_start  in  2  0 none, 1 mult-class, 2 div-class
- D_md_use  in  1  instruction in D reads/writes HI/LO or starts mult/div
- stall  out  1  freeze PC and IF/ID; clear ID/EX (bubble)
- md_busy  out  1  mult/div unit busy
- fwd_D_rs, fwd_D_rt  out  2 each  0 GRF, 1 E, 2 M, 3 W
- fwd_E_rs, fwd_E_rt  out  2 each  0 pipe reg, 2 M, 3 W
- fwd_M_rt  out  2  0 pipe reg, 3 W

Behaviour:
- Scoreboard: one entry per E/M/W stage, fields wa[4:0], tnew[1:0], rs[4:0], rt[4:0], md[1:0].
- Every rising edge, when reset=1:
  - E is loaded from the D inputs, or with a bubble (all fields 0) if stall=1.
  - M is loaded from E, and W from M; tnew saturating-decrements on each move.
- reset=0: all entries become bubbles and the md counter goes to 0. This is valid mid-stall or mid-multiply, and all outputs are 0 in the following cycle.
- match(X, r) = (r != 0) && (X.wa == r).
- Stall condition: stall=1 iff any of:
  - for r in {rs, rt} with tuse != 3, some X in {E, M} has match(X, r) and tuse < X.tnew;
  - D_md_use && (md_busy || E.md != 0).
- Stall is combinational from current state and D inputs; it has no registered latency.
- Forward select = the nearest stage with match and tnew == 0, priority E > M > W; no match gives 0.
  - D-stage selects: search E, M, W against D_rs/D_rt.
  - E-stage selects: search M, W against E.rs/E.rt.
  - M-stage select: search W against M.rt.
- An entry with tnew > 0 is never forwarded; a stall is guaranteed in that case whenever tuse demands the value.
- Register 0 never matches: a write to $0 generates neither a stall nor a forward.
- Mult/div counter:
  - When E.md != 0 at a rising edge, the counter loads MULT_CYC or DIV_CYC.
  - Otherwise, if it is nonzero, it decrements.
  - md_busy = (counter != 0).
  - A new start is impossible while busy, because the md_use stall holds it in D.
- Simultaneous events: a data stall and an md stall both assert the same single stall.
- The W stage is written to the GRF in the same cycle the GRF internally bypasses, so W never causes a stall.

Optional Feature:
- Macro: HAZARD_FWD_EN.
- Defined: forwarding and stall behave as above.
- Undefined:
  - All fwd_* outputs are tied to 0.
  - Stall = any used source (tuse != 3) matching E or M regardless of tnew, plus the md rule.
  - The scoreboard is unchanged, so timing of other logic is unaffected.

Decomposition:
- Package hazard_pkg holds:
  - FWD_GRF=0, FWD_E=1, FWD_M=2, FWD_W=3;
  - TUSE_NONE=3;
  - MD_NONE/MD_MULT/MD_DIV;
  - a packed struct sb_entry_t {wa, tnew, rs, rt, md}.
- One sub-module: hazard_fwd_sel, the combinational priority match of one operand against up to three entries, instantiated 5 times.

Test Plan:
- lw $1 in D (tnew=2), then addu $2,$1,$3 (rs_tuse=1):
  - 1 stall cycle;
  - then fwd_E_rs=3 once lw reaches W.
- addu $1 followed by beq $1 (tuse=0):
  - 1 stall;
  - next cycle fwd_D_rs=2.
- jal (wa=31, tnew=0) then jr $31 (tuse=0): no stall; fwd_D_rs=1.
- addu $0,$4,$5 then addu $6,$0,$0: stall=0, all fwd=0.
- div in D, then mflo 2 cycles later:
  - md_busy high for 10 cycles;
  - mflo stalls until busy falls and then issues;
  - assert reset=0 during the 5th busy cycle: the next cycle md_busy=0 and stall=0.
- Without HAZARD_FWD_EN: addu $1 then addu $2,$1,$1 gives 2 stall cycles; fwd outputs are constant 0.
